// File: rtl/cache_controller_pkg.sv
// Shared constants and the FSM state encoding for the cache controller.
// Holds no logic. The cache_set_array port widths use TAG_W. BASE_ADDR is
// the default data-memory base for cache_controller.
package cache_controller_pkg;

    localparam int TAG_W     = 10;
    localparam int INDEX_W   = 6;
    localparam int BASE_ADDR = 1024;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FILL_LO = 3'd1,
        S_FILL_HI = 3'd2,
        S_WRITE   = 3'd3,
        S_RESP    = 3'd4
    } state_t;

endpackage

// File: rtl/cache_controller_set_array.sv
// cache_set_array: storage for a two-way set-associative cache with
// two-word blocks.
//
// Each set holds the following for each way: a valid bit, a tag and a
// 64-bit block. Each set also has one LRU bit, where 0 selects way0 as
// the victim.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears valid + LRU)
//   i_index/i_tag   set index and tag of the current CPU address
//   i_word_sel      word within the block (0 = low word)
//   o_hit           valid tag match in either way (combinational)
//   o_hit_way       which way matched
//   o_word          selected word of the hit way
//   i_touch_en      read hit: point LRU away from the hit way
//   i_fill_en       write i_fill_block into the victim way, mark valid
//   i_fill_block    {hi word, lo word}
//   i_upd_en        write hit: replace the selected word in the hit way
//   i_upd_data      new word for an update
module cache_set_array
    import cache_controller_pkg::*;
#(
    parameter int NUM_SETS = 64,
    parameter int IDX_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_index,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_word_sel,
    output logic             o_hit,
    output logic             o_hit_way,
    output logic [31:0]      o_word,
    input  logic             i_touch_en,
    input  logic             i_fill_en,
    input  logic [63:0]      i_fill_block,
    input  logic             i_upd_en,
    input  logic [31:0]      i_upd_data
);

    logic [1:0][NUM_SETS-1:0] r_valid;
    logic [NUM_SETS-1:0]      r_lru;
    logic [TAG_W-1:0]         r_tag  [2][NUM_SETS];
    logic [63:0]              r_data [2][NUM_SETS];

    logic        w_hit0;
    logic        w_hit1;
    logic        w_victim;
    logic [63:0] w_block;

    assign w_hit0    = r_valid[0][i_index] && (r_tag[0][i_index] == i_tag);
    assign w_hit1    = r_valid[1][i_index] && (r_tag[1][i_index] == i_tag);
    assign o_hit     = w_hit0 || w_hit1;
    assign o_hit_way = w_hit1;
    assign w_victim  = r_lru[i_index];
    assign w_block   = w_hit1 ? r_data[1][i_index] : r_data[0][i_index];
    assign o_word    = i_word_sel ? w_block[63:32] : w_block[31:0];

    // Valid and LRU state is the only storage that reset has to restore.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            r_lru   <= '0;
        end else if (i_fill_en) begin
            r_valid[w_victim][i_index] <= 1'b1;
            r_lru[i_index]             <= ~w_victim;
        end else if ((i_touch_en || i_upd_en) && o_hit) begin
            r_lru[i_index] <= ~o_hit_way;
        end
    end

    // Tags and data are don't-care until their valid bit is set, so this
    // block has no reset.
    always_ff @(posedge clk) begin
        if (i_fill_en) begin
            r_tag[w_victim][i_index]  <= i_tag;
            r_data[w_victim][i_index] <= i_fill_block;
        end else if (i_upd_en && o_hit) begin
            if (i_word_sel) begin
                r_data[o_hit_way][i_index][63:32] <= i_upd_data;
            end else begin
                r_data[o_hit_way][i_index][31:0] <= i_upd_data;
            end
        end
    end

endmodule

// File: rtl/cache_controller.sv
// cache_controller: a two-way set-associative data cache between the MEM
// stage and the SRAM controller. Writes go through to SRAM, and a write
// miss does not allocate a line.
//
// Read hits complete in the same cycle. A read miss fills a two-word block
// using two SRAM reads.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cpu_rd_en / cpu_wr_en    MEM-stage request, held until cpu_ready
//   cpu_address, cpu_wdata   word-aligned byte address, write data
//   cpu_rdata, cpu_ready     read data / completion (0 stalls the pipeline)
//   sram_rd_en / sram_wr_en  requests to the SRAM controller
//   sram_address/wdata       un-offset byte address and write data
//   sram_rdata, sram_ready   SRAM read data, one-cycle completion pulse
//
// state     | meaning
// ----------+-----------------------------------------------------
// S_IDLE    | serve read hits, launch miss fills and writes
// S_FILL_LO | SRAM read of the low word of the block
// S_FILL_HI | SRAM read of the high word, then install the block
// S_WRITE   | SRAM write-through, update the word on a hit
// S_RESP    | one-cycle cpu_ready for a miss or a write
module cache_controller #(
    parameter int NUM_SETS  = 64,
    parameter int BASE_ADDR = cache_controller_pkg::BASE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_rd_en,
    input  logic        cpu_wr_en,
    input  logic [31:0] cpu_address,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_ready,
    output logic        sram_rd_en,
    output logic        sram_wr_en,
    output logic [31:0] sram_address,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    input  logic        sram_ready
);

    import cache_controller_pkg::*;

    localparam int          SET_IDX_W = $clog2(NUM_SETS);
    localparam int          OFF_W     = 3 + SET_IDX_W + TAG_W;
    localparam logic [31:0] BASE_VEC  = 32'(BASE_ADDR);

    state_t r_state;
    state_t w_next_state;
    logic [31:0] r_lo;
    logic [31:0] r_hi;

    // Only the bits from the word select up to the top of the tag are
    // needed. BASE_ADDR is word aligned, so the subtraction does not need
    // the two byte-offset bits.
    logic [OFF_W-1:2]     w_off;
    logic                 w_word_sel;
    logic [SET_IDX_W-1:0] w_index;
    logic [TAG_W-1:0]     w_tag;
    logic [31:0]          w_block_base;

    logic        w_hit;
    logic        w_hit_way;
    logic [31:0] w_hit_word;
    logic        w_touch_en;
    logic        w_fill_en;
    logic        w_upd_en;

    assign w_off        = cpu_address[OFF_W-1:2] - BASE_VEC[OFF_W-1:2];
    assign w_word_sel   = w_off[2];
    assign w_index      = w_off[3 +: SET_IDX_W];
    assign w_tag        = w_off[3 + SET_IDX_W +: TAG_W];
    assign w_block_base = {cpu_address[31:3], 1'b0, cpu_address[1:0]};

    cache_set_array #(
        .NUM_SETS (NUM_SETS),
        .IDX_W    (SET_IDX_W)
    ) u_set_array (
        .clk          (clk),
        .rst          (rst),
        .i_index      (w_index),
        .i_tag        (w_tag),
        .i_word_sel   (w_word_sel),
        .o_hit        (w_hit),
        .o_hit_way    (w_hit_way),
        .o_word       (w_hit_word),
        .i_touch_en   (w_touch_en),
        .i_fill_en    (w_fill_en),
        .i_fill_block ({sram_rdata, r_lo}),
        .i_upd_en     (w_upd_en),
        .i_upd_data   (cpu_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_lo    <= '0;
            r_hi    <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_FILL_LO && sram_ready) begin
                r_lo <= sram_rdata;
            end
            if (r_state == S_FILL_HI && sram_ready) begin
                r_hi <= sram_rdata;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        cpu_ready    = 1'b0;
        cpu_rdata    = '0;
        sram_rd_en   = 1'b0;
        sram_wr_en   = 1'b0;
        sram_address = '0;
        sram_wdata   = '0;
        w_touch_en   = 1'b0;
        w_fill_en    = 1'b0;
        w_upd_en     = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cpu_wr_en) begin
                    w_next_state = S_WRITE;
                end else if (cpu_rd_en) begin
                    if (w_hit) begin
                        cpu_ready  = 1'b1;
                        cpu_rdata  = w_hit_word;
                        w_touch_en = 1'b1;
                    end else begin
                        w_next_state = S_FILL_LO;
                    end
                end else begin
                    cpu_ready = 1'b1;
                end
            end
            S_FILL_LO: begin
                sram_rd_en   = 1'b1;
                sram_address = w_block_base;
                if (sram_ready) begin
                    w_next_state = S_FILL_HI;
                end
            end
            S_FILL_HI: begin
                sram_rd_en   = 1'b1;
                sram_address = w_block_base + 32'd4;
                if (sram_ready) begin
                    w_fill_en    = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_WRITE: begin
                sram_wr_en   = 1'b1;
                sram_address = cpu_address;
                sram_wdata   = cpu_wdata;
                if (sram_ready) begin
                    w_upd_en     = 1'b1;
                    w_next_state = S_RESP;
                end
            end
            S_RESP: begin
                cpu_ready = 1'b1;
                if (cpu_rd_en && !cpu_wr_en) begin
                    cpu_rdata = w_word_sel ? r_hi : r_lo;
                end
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller. The SRAM model has a fixed
// latency. A scoreboard queue holds the SRAM transactions and the CPU read
// data that each request should produce.
module tb_cache_controller;

    localparam int SRAM_LAT = 2;
    localparam int K_HIT    = 0;
    localparam int K_MISS   = 1;
    localparam int K_WRITE  = 2;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          kind;
    } vec_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_rd_en, cpu_wr_en;
    logic [31:0] cpu_address, cpu_wdata, cpu_rdata;
    logic        cpu_ready;
    logic        sram_rd_en, sram_wr_en;
    logic [31:0] sram_address, sram_wdata;
    logic [31:0] sram_rdata;
    logic        sram_ready;

    int checks = 0;
    int errors = 0;

    txn_t        exp_sram_q[$];
    logic [31:0] exp_cpu_q[$];
    vec_t        vecs[12];

    logic [31:0] mem [1024];
    int          lat_cnt;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_rd_en    (cpu_rd_en),
        .cpu_wr_en    (cpu_wr_en),
        .cpu_address  (cpu_address),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_ready    (cpu_ready),
        .sram_rd_en   (sram_rd_en),
        .sram_wr_en   (sram_wr_en),
        .sram_address (sram_address),
        .sram_wdata   (sram_wdata),
        .sram_rdata   (sram_rdata),
        .sram_ready   (sram_ready)
    );

    function automatic int widx(input logic [31:0] a);
        logic [31:0] w;
        w = (a - 32'd1024) >> 2;
        return int'(w[9:0]);
    endfunction

    // SRAM controller model with a fixed latency.
    always @(posedge clk) begin
        if (rst) begin
            sram_ready <= 1'b0;
            lat_cnt    <= 0;
        end else if (sram_ready) begin
            sram_ready <= 1'b0;
            lat_cnt    <= 0;
        end else if (sram_rd_en || sram_wr_en) begin
            if (lat_cnt == SRAM_LAT - 1) begin
                sram_ready <= 1'b1;
                lat_cnt    <= 0;
                if (sram_wr_en) mem[widx(sram_address)] <= sram_wdata;
                else            sram_rdata <= mem[widx(sram_address)];
            end else begin
                lat_cnt <= lat_cnt + 1;
            end
        end
    end

    // Bus monitor: handshake rules and the SRAM transaction scoreboard.
    logic        prev_en = 1'b0;
    logic        prev_ready = 1'b0;
    logic [31:0] prev_addr = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_en    = 1'b0;
            prev_ready = 1'b0;
        end else begin
            if (sram_rd_en && sram_wr_en) begin
                checks++; errors++;
                $display("FAIL both_en: rd_en=1 wr_en=1, required at most one");
            end
            if ((sram_rd_en || sram_wr_en) && exp_sram_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_en: addr=%h rd=%b wr=%b, required idle bus",
                         sram_address, sram_rd_en, sram_wr_en);
            end
            if (prev_en && (sram_rd_en || sram_wr_en) && !prev_ready && sram_address != prev_addr) begin
                checks++; errors++;
                $display("FAIL addr_stable: got %h, required %h", sram_address, prev_addr);
            end
            if (sram_ready) begin
                txn_t t;
                checks++;
                if (exp_sram_q.size() == 0) begin
                    errors++;
                    $display("FAIL sram_txn: got addr=%h with none expected", sram_address);
                end else begin
                    t = exp_sram_q.pop_front();
                    if (sram_wr_en !== t.we || sram_address !== t.addr ||
                        (t.we && sram_wdata !== t.wdata)) begin
                        errors++;
                        $display("FAIL sram_txn: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                 sram_wr_en, sram_address, sram_wdata, t.we, t.addr, t.wdata);
                    end
                end
            end
            prev_en    = sram_rd_en || sram_wr_en;
            prev_ready = sram_ready;
            prev_addr  = sram_address;
        end
    end

    task automatic run_req(input vec_t v, input string name);
        int          cycles;
        logic [31:0] exp_rd;
        logic [31:0] base;
        @(negedge clk);
        cpu_rd_en   = v.rd;
        cpu_wr_en   = v.wr;
        cpu_address = v.addr;
        cpu_wdata   = v.wdata;
        base = {v.addr[31:3], 3'b000};
        if (v.kind == K_MISS) begin
            exp_sram_q.push_back('{we: 1'b0, addr: base,         wdata: 32'h0});
            exp_sram_q.push_back('{we: 1'b0, addr: base + 32'd4, wdata: 32'h0});
        end else if (v.kind == K_WRITE) begin
            exp_sram_q.push_back('{we: 1'b1, addr: v.addr, wdata: v.wdata});
        end
        exp_cpu_q.push_back(v.exp_rdata);
        cycles = 0;
        #2;
        while (!cpu_ready && cycles <= 100) begin
            @(negedge clk);
            #2;
            cycles++;
        end
        exp_rd = exp_cpu_q.pop_front();
        checks++;
        if (!cpu_ready) begin
            errors++;
            $display("FAIL %s timeout: no cpu_ready after %0d cycles", name, cycles);
        end else begin
            checks++;
            if ((v.kind == K_HIT) != (cycles == 0)) begin
                errors++;
                $display("FAIL %s latency: got %0d stall cycles, required %s", name, cycles,
                         (v.kind == K_HIT) ? "0" : "nonzero");
            end
            if (v.rd && !v.wr) begin
                checks++;
                if (cpu_rdata !== exp_rd) begin
                    errors++;
                    $display("FAIL %s rdata: got %h, required %h", name, cpu_rdata, exp_rd);
                end
            end
        end
        @(posedge clk);
        #1;
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;
        checks++;
        if (exp_sram_q.size() != 0) begin
            errors++;
            $display("FAIL %s sram_count: %0d transactions outstanding, required 0",
                     name, exp_sram_q.size());
            exp_sram_q.delete();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int wait_cyc;
        vec_t v;

        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[widx(32'd1024)] = 32'hAAAA0001;
        mem[widx(32'd1028)] = 32'hBBBB0002;
        mem[widx(32'd1536)] = 32'h15360000;
        mem[widx(32'd1540)] = 32'h15400004;
        mem[widx(32'd2048)] = 32'h20480000;
        mem[widx(32'd2052)] = 32'h20520004;

        //            rd    wr    addr         wdata          exp_rdata      kind
        vecs[0]  = '{1'b1, 1'b0, 32'd1028, 32'h0,         32'hBBBB0002, K_MISS};
        vecs[1]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         32'hAAAA0001, K_HIT};
        vecs[2]  = '{1'b0, 1'b1, 32'd1024, 32'h12345678,  32'h0,        K_WRITE};
        vecs[3]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         32'h12345678, K_HIT};
        vecs[4]  = '{1'b0, 1'b1, 32'd2048, 32'hDEADBEEF,  32'h0,        K_WRITE};
        vecs[5]  = '{1'b1, 1'b0, 32'd1536, 32'h0,         32'h15360000, K_MISS};
        vecs[6]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         32'h12345678, K_HIT};
        vecs[7]  = '{1'b1, 1'b0, 32'd2048, 32'h0,         32'hDEADBEEF, K_MISS};
        vecs[8]  = '{1'b1, 1'b0, 32'd1024, 32'h0,         32'h12345678, K_HIT};
        vecs[9]  = '{1'b1, 1'b0, 32'd1536, 32'h0,         32'h15360000, K_MISS};
        vecs[10] = '{1'b1, 1'b1, 32'd1032, 32'hCAFEF00D,  32'h0,        K_WRITE};
        vecs[11] = '{1'b1, 1'b0, 32'd1032, 32'h0,         32'hCAFEF00D, K_MISS};

        rst = 1'b1;
        cpu_rd_en = 1'b0;
        cpu_wr_en = 1'b0;
        cpu_address = '0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (cpu_ready !== 1'b1 || sram_rd_en !== 1'b0 || sram_wr_en !== 1'b0 ||
            sram_address !== 32'h0 || cpu_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: ready=%b rd=%b wr=%b addr=%h rdata=%h, required 1 0 0 0 0",
                     cpu_ready, sram_rd_en, sram_wr_en, sram_address, cpu_rdata);
        end
        rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset while a fill of 2052 is in progress (2052 was evicted above).
        @(negedge clk);
        cpu_rd_en   = 1'b1;
        cpu_address = 32'd2052;
        exp_sram_q.push_back('{we: 1'b0, addr: 32'd2048, wdata: 32'h0});
        wait_cyc = 0;
        while (!sram_rd_en && wait_cyc < 20) begin
            @(negedge clk);
            wait_cyc++;
        end
        checks++;
        if (!sram_rd_en) begin
            errors++;
            $display("FAIL rst_fill_start: sram_rd_en never rose");
        end
        rst       = 1'b1;
        cpu_rd_en = 1'b0;
        @(posedge clk);
        #1;
        exp_sram_q.delete();
        checks++;
        if (sram_rd_en !== 1'b0 || cpu_ready !== 1'b1 || sram_address !== 32'h0) begin
            errors++;
            $display("FAIL rst_midfill: rd_en=%b ready=%b addr=%h, required 0 1 0",
                     sram_rd_en, cpu_ready, sram_address);
        end
        rst = 1'b0;

        v = '{1'b1, 1'b0, 32'd1024, 32'h0, 32'h12345678, K_MISS};
        run_req(v, "post_rst_miss");
        v = '{1'b1, 1'b0, 32'd1024, 32'h0, 32'h12345678, K_HIT};
        run_req(v, "post_rst_hit");
        v = '{1'b1, 1'b0, 32'd1540, 32'h0, 32'h15400004, K_MISS};
        run_req(v, "hi_word_miss");

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
